// File: rtl/race_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer_pkg
// Description : Shared game definitions for the race sequencer. It holds the
//               race state enumeration, the default lap and countdown
//               constants, and small state-decode helpers used by the top.
// Revision    : 1.0 - initial release
// ============================================================================
package race_sequencer_pkg;

    // Default number of laps per race (legal range 1..15).
    localparam int unsigned DEFAULT_LAPS      = 3;
    // Default first countdown digit (legal range 1..9).
    localparam int unsigned DEFAULT_COUNTDOWN = 3;

    // Race phases. The width is explicit so the state register has a fixed
    // size that does not depend on how many states exist.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_GO        = 3'd2,
        ST_RACING    = 3'd3,
        ST_FINISHED  = 3'd4,
        ST_DNF       = 3'd5
    } race_state_t;

    // True while the car may drive: the lap timer runs, controls pass through,
    // and lap / timeout events are acted on.
    function automatic logic is_live(input race_state_t s);
        return (s == ST_GO) || (s == ST_RACING);
    endfunction

    // True while the countdown overlay (a digit or "GO") is on screen.
    function automatic logic is_overlay(input race_state_t s);
        return (s == ST_COUNTDOWN) || (s == ST_GO);
    endfunction

endpackage : race_sequencer_pkg
`default_nettype wire

// File: rtl/race_sequencer_sec_tick.sv
`default_nettype none
// ============================================================================
// Module      : sec_tick
// Description : Seconds divider for the race sequencer. Counts pclk cycles
//               from 0 to CYCLES_PER_SEC-1 while enabled and raises tick for
//               the single cycle on which the count sits at its last value,
//               wrapping back to 0 on the following edge. A clear restarts
//               the count at 0 so every state starts with a full second.
// Ports       : pclk   - pixel clock
//               rst    - synchronous, active-high reset
//               clear  - restart the second from 0 on the next edge
//               enable - count this cycle
//               tick   - one-cycle pulse marking the end of a second
// Revision    : 1.0 - initial release
// ============================================================================
module sec_tick #(
    parameter int unsigned CYCLES_PER_SEC = 65_000_000
) (
    input  logic pclk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    // A one-cycle second still needs a one-bit counter to stay well formed.
    localparam int unsigned CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CYCLES_PER_SEC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The tick is decoded from the registered count so it is glitch-free and
    // lines up with the cycle in which the state machine acts on it.
    assign tick = enable && (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : sec_tick
`default_nettype wire

// File: rtl/race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer
// Description : Race flow controller. Runs a digit countdown followed by a
//               one-second "GO", then a race of LAPS laps that ends either in
//               FINISHED (all laps done) or DNF (lap time limit exceeded).
//               Dropping game_visible returns to IDLE from anywhere. Every
//               output comes straight from a flop.
// Ports       : pclk              - 65 MHz pixel clock, the only clock
//               rst               - synchronous, active-high reset
//               game_visible      - high while the game screen is shown
//               lap_finished      - one-cycle pulse per valid lap
//               max_time_exceeded - lap time limit reached (level)
//               controls_in       - raw car controls {R,L,D,U}
//               controls_out      - controls passed to the car, 0 when frozen
//               timer_run         - lap timer enable
//               countdown_visible - countdown digit or "GO" on screen
//               countdown_digit   - digit to show, 0 meaning "GO"
//               lap_count         - completed laps
//               race_finished     - race completed
//               race_dnf          - race ended by timeout
// Revision    : 1.0 - initial release
// ============================================================================
module race_sequencer
    import race_sequencer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SEC = 65_000_000,
    parameter int unsigned LAPS           = DEFAULT_LAPS,
    parameter int unsigned COUNTDOWN      = DEFAULT_COUNTDOWN
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       game_visible,
    input  logic       lap_finished,
    input  logic       max_time_exceeded,
    input  logic [3:0] controls_in,
    output logic [3:0] controls_out,
    output logic       timer_run,
    output logic       countdown_visible,
    output logic [3:0] countdown_digit,
    output logic [3:0] lap_count,
    output logic       race_finished,
    output logic       race_dnf
);

    localparam logic [3:0] LAPS_TARGET = 4'(LAPS);
    localparam logic [3:0] FIRST_DIGIT = 4'(COUNTDOWN);

    race_state_t state_q;
    race_state_t state_d;
    logic [3:0]  digit_q;
    logic [3:0]  digit_d;
    logic [3:0]  laps_q;
    logic [3:0]  laps_d;
    logic [3:0]  controls_q;
    logic        timer_run_q;
    logic        overlay_q;
    logic        finished_q;
    logic        dnf_q;

    logic        sec_done;
    logic        sec_clear;
    logic        sec_enable;
    logic [3:0]  laps_inc;

    // ------------------------------------------------------------------------
    // Second divider. Clearing on every state change means a state is always
    // entered with a fresh second; countdown digit changes reuse the natural
    // wrap of the counter instead.
    // ------------------------------------------------------------------------
    assign sec_clear  = (state_d != state_q);
    assign sec_enable = (state_q == ST_COUNTDOWN) || (state_q == ST_GO);

    sec_tick #(
        .CYCLES_PER_SEC (CYCLES_PER_SEC)
    ) u_sec_tick (
        .pclk   (pclk),
        .rst    (rst),
        .clear  (sec_clear),
        .enable (sec_enable),
        .tick   (sec_done)
    );

    assign laps_inc = laps_q + 4'd1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        laps_d  = laps_q;

        if (!game_visible) begin
            // Leaving the game screen abandons whatever is in progress.
            state_d = ST_IDLE;
            digit_d = 4'd0;
            laps_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COUNTDOWN;
                    digit_d = FIRST_DIGIT;
                    laps_d  = 4'd0;
                end

                ST_COUNTDOWN: begin
                    if (sec_done) begin
                        if (digit_q == 4'd1) begin
                            state_d = ST_GO;
                            digit_d = 4'd0;
                        end else begin
                            digit_d = digit_q - 4'd1;
                        end
                    end
                end

                ST_GO, ST_RACING: begin
                    if (state_q == ST_GO && sec_done) begin
                        state_d = ST_RACING;
                    end
                    // A lap completing on the same cycle as the timeout still
                    // counts; race-ending outcomes override the GO expiry.
                    if (lap_finished) begin
                        laps_d = laps_inc;
                        if (laps_inc == LAPS_TARGET) begin
                            state_d = ST_FINISHED;
                        end
                    end else if (max_time_exceeded) begin
                        state_d = ST_DNF;
                    end
                end

                ST_FINISHED, ST_DNF: begin
                    // Terminal until the game screen is left.
                end

                default: begin
                    state_d = ST_IDLE;
                    digit_d = 4'd0;
                    laps_d  = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers. Status outputs are decoded from the next
    // state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            digit_q     <= 4'd0;
            laps_q      <= 4'd0;
            controls_q  <= 4'd0;
            timer_run_q <= 1'b0;
            overlay_q   <= 1'b0;
            finished_q  <= 1'b0;
            dnf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            laps_q      <= laps_d;
            controls_q  <= is_live(state_d) ? controls_in : 4'd0;
            timer_run_q <= is_live(state_d);
            overlay_q   <= is_overlay(state_d);
            finished_q  <= (state_d == ST_FINISHED);
            dnf_q       <= (state_d == ST_DNF);
        end
    end

    assign controls_out      = controls_q;
    assign timer_run         = timer_run_q;
    assign countdown_visible = overlay_q;
    assign countdown_digit   = digit_q;
    assign lap_count         = laps_q;
    assign race_finished     = finished_q;
    assign race_dnf          = dnf_q;

endmodule : race_sequencer
`default_nettype wire

// File: tb/tb_race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_race_sequencer
// Description : Self-checking bench for race_sequencer with a one-second
//               period of 10 cycles, 2 laps and a countdown starting at 3.
//               The reference model tracks elapsed cycles since the race
//               started and derives the phase from that time directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_race_sequencer;

    localparam int CPS  = 10;
    localparam int LAPS = 2;
    localparam int CD   = 3;

    logic       pclk = 1'b0;
    logic       rst;
    logic       game_visible;
    logic       lap_finished;
    logic       max_time_exceeded;
    logic [3:0] controls_in;
    logic [3:0] controls_out;
    logic       timer_run;
    logic       countdown_visible;
    logic [3:0] countdown_digit;
    logic [3:0] lap_count;
    logic       race_finished;
    logic       race_dnf;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    race_sequencer #(
        .CYCLES_PER_SEC (CPS),
        .LAPS           (LAPS),
        .COUNTDOWN      (CD)
    ) dut (
        .pclk              (pclk),
        .rst               (rst),
        .game_visible      (game_visible),
        .lap_finished      (lap_finished),
        .max_time_exceeded (max_time_exceeded),
        .controls_in       (controls_in),
        .controls_out      (controls_out),
        .timer_run         (timer_run),
        .countdown_visible (countdown_visible),
        .countdown_digit   (countdown_digit),
        .lap_count         (lap_count),
        .race_finished     (race_finished),
        .race_dnf          (race_dnf)
    );

    // {controls, timer_run, visible, digit, laps, finished, dnf}
    wire [15:0] act_vec = {controls_out, timer_run, countdown_visible,
                           countdown_digit, lap_count, race_finished, race_dnf};

    // ---------------------------------------------------------------- model
    bit         m_active;   // a race sequence has started since last IDLE
    int         m_t;        // cycles since the countdown began
    int         m_end;      // 0 running, 1 finished, 2 dnf
    int         m_laps;
    logic [3:0] m_ctrl;

    function automatic logic [15:0] exp_vec();
        bit         live    = m_active && (m_end == 0);
        bit         in_race = live && (m_t >= CD * CPS);
        bit         vis     = live && (m_t < (CD + 1) * CPS);
        logic [3:0] dig     = (live && m_t < CD * CPS) ? 4'(CD - m_t / CPS) : 4'd0;
        return {m_ctrl, in_race, vis, dig, 4'(m_laps), (m_end == 1), (m_end == 2)};
    endfunction

    task automatic model_step();
        if (rst || !game_visible) begin
            m_active = 1'b0;
            m_t      = 0;
            m_laps   = 0;
            m_end    = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
            m_laps   = 0;
            m_end    = 0;
        end else begin
            if (m_end == 0 && m_t >= CD * CPS) begin
                if (lap_finished) begin
                    m_laps++;
                    if (m_laps == LAPS) m_end = 1;
                end else if (max_time_exceeded) begin
                    m_end = 2;
                end
            end
            m_t++;
        end
        m_ctrl = (m_active && m_end == 0 && m_t >= CD * CPS) ? controls_in : 4'd0;
    endtask

    // One clock: inputs already stable, model follows the edge, sample 1ns later.
    task automatic cyc();
        @(posedge pclk);
        model_step();
        #1;
    endtask

    task automatic restart_to_racing();
        game_visible = 1'b0;
        cyc();
        game_visible = 1'b1;
        repeat ((CD + 1) * CPS + 1) cyc();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; game_visible = 1'b1; lap_finished = 1'b1;
        max_time_exceeded = 1'b1; controls_in = 4'hF;
        repeat (3) cyc();
        total++;
        if (act_vec !== 16'h0000) begin
            bad++; $display("FAIL reset_outputs: actual=%h expected=%h", act_vec, 16'h0000);
        end
        rst = 1'b0; game_visible = 1'b0; lap_finished = 1'b0;
        max_time_exceeded = 1'b0; controls_in = 4'h0;
        cyc();
        total++;
        if (act_vec !== 16'h0000) begin
            bad++; $display("FAIL idle_after_reset: actual=%h expected=%h", act_vec, 16'h0000);
        end
    endtask

    task automatic test_countdown();
        game_visible = 1'b1;
        controls_in  = 4'b1001;
        for (int i = 0; i < (CD + 2) * CPS; i++) begin
            cyc();
            total++;
            if (act_vec !== exp_vec()) begin
                bad++; $display("FAIL countdown cyc=%0d: actual=%h expected=%h", i, act_vec, exp_vec());
            end
            if (i == 0 || i == 10 || i == 20 || i == 30) begin
                total++;
                if (countdown_digit !== 4'(i < 30 ? 3 - i / 10 : 0)) begin
                    bad++; $display("FAIL digit cyc=%0d: actual=%0d expected=%0d", i, countdown_digit, i < 30 ? 3 - i / 10 : 0);
                end
            end
            if (i == 29 || i == 30 || i == 40) begin
                total++;
                if ({timer_run, controls_out} !== ((i == 29) ? 5'b0_0000 : 5'b1_1001)) begin
                    bad++; $display("FAIL go_edge cyc=%0d: actual=%b expected timer/ctl change at 30", i, {timer_run, controls_out});
                end
            end
        end
    endtask

    task automatic test_laps();
        // Still racing from test_countdown.
        lap_finished = 1'b1; cyc(); lap_finished = 1'b0;
        total++;
        if (lap_count !== 4'd1 || race_finished !== 1'b0) begin
            bad++; $display("FAIL lap_one: actual laps=%0d fin=%b expected laps=1 fin=0", lap_count, race_finished);
        end
        repeat (4) cyc();
        lap_finished = 1'b1; cyc(); lap_finished = 1'b0;
        total++;
        if ({lap_count, race_finished, timer_run, controls_out} !== {4'd2, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL lap_two_finish: actual laps=%0d fin=%b run=%b ctl=%b expected 2/1/0/0000",
                            lap_count, race_finished, timer_run, controls_out);
        end
        // Further laps after finishing must not move the count.
        lap_finished = 1'b1; repeat (3) cyc(); lap_finished = 1'b0;
        total++;
        if (act_vec !== exp_vec() || lap_count !== 4'd2) begin
            bad++; $display("FAIL finished_hold: actual=%h expected=%h", act_vec, exp_vec());
        end
    endtask

    task automatic test_dnf();
        restart_to_racing();
        max_time_exceeded = 1'b1; cyc(); max_time_exceeded = 1'b0;
        total++;
        if ({race_dnf, lap_count, timer_run} !== {1'b1, 4'd0, 1'b0}) begin
            bad++; $display("FAIL dnf: actual dnf=%b laps=%0d run=%b expected 1/0/0", race_dnf, lap_count, timer_run);
        end
        restart_to_racing();
        lap_finished = 1'b1; max_time_exceeded = 1'b1; cyc();
        lap_finished = 1'b0; max_time_exceeded = 1'b0;
        total++;
        if ({race_dnf, lap_count, timer_run} !== {1'b0, 4'd1, 1'b1}) begin
            bad++; $display("FAIL lap_and_timeout: actual dnf=%b laps=%0d run=%b expected 0/1/1", race_dnf, lap_count, timer_run);
        end
    endtask

    task automatic test_abort();
        game_visible = 1'b0; cyc(); game_visible = 1'b1;
        repeat (15) cyc();
        game_visible = 1'b0; cyc();
        total++;
        if (act_vec !== 16'h0000) begin
            bad++; $display("FAIL drop_mid_countdown: actual=%h expected=%h", act_vec, 16'h0000);
        end
        restart_to_racing();
        rst = 1'b1; cyc(); rst = 1'b0;
        total++;
        if (act_vec !== 16'h0000) begin
            bad++; $display("FAIL rst_mid_race: actual=%h expected=%h", act_vec, 16'h0000);
        end
        cyc();
        total++;
        if ({countdown_visible, countdown_digit} !== {1'b1, 4'd3}) begin
            bad++; $display("FAIL restart_after_rst: actual vis=%b digit=%0d expected 1/3", countdown_visible, countdown_digit);
        end
    endtask

    task automatic test_lap_in_countdown();
        game_visible = 1'b0; cyc(); game_visible = 1'b1;
        lap_finished = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cyc();
            total++;
            if (lap_count !== 4'd0) begin
                bad++; $display("FAIL lap_in_countdown cyc=%0d: actual=%0d expected=0", i, lap_count);
            end
        end
        lap_finished = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst               = ($urandom_range(0, 99) == 0);
            game_visible      = ($urandom_range(0, 59) != 0);
            lap_finished      = ($urandom_range(0, 11) == 0);
            max_time_exceeded = ($urandom_range(0, 39) == 0);
            controls_in       = 4'($urandom_range(0, 15));
            cyc();
            total++;
            if (act_vec !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d: actual=%h expected=%h", i, act_vec, exp_vec());
            end
        end
        rst = 1'b0; lap_finished = 1'b0; max_time_exceeded = 1'b0;
    endtask

    initial begin
        rst = 1'b1; game_visible = 1'b0; lap_finished = 1'b0;
        max_time_exceeded = 1'b0; controls_in = 4'h0;
        m_active = 1'b0; m_t = 0; m_end = 0; m_laps = 0; m_ctrl = 4'h0;
        test_reset();
        test_countdown();
        test_laps();
        test_dnf();
        test_abort();
        test_lap_in_countdown();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_race_sequencer
`default_nettype wire
